pipeline_trace_buffer: RTL and testbench
========================================

PIPELINE_TRACE_BUFFER -- requirements
Module: pipeline_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one channel word.
REQ-002 SHALL have parameter CHANNELS, default 4, number of pipeline-stage channels captured per sample.
REQ-003 SHALL have parameter DEPTH, default 64, sample entries; power of two, >= 4.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port SAMPLE_EN  input  1  capture CH_DATA this cycle.
REQ-007 SHALL have port CH_DATA  input  CHANNELS*DATA_W  stage words; channel 0 in bits [DATA_W-1:0], which is the PC.
REQ-008 SHALL have port TRIG_PC  input  DATA_W  trigger compare value for channel 0.
REQ-009 SHALL have port ARM  input  1  start a capture; single-cycle pulse.
REQ-010 SHALL have port POST_COUNT  input  log2(DEPTH)  samples captured after the trigger sample.
REQ-011 SHALL have port RD_REQ  input  1  request the next stored entry.
REQ-012 SHALL have port RD_VALID  output  1  RD_DATA/RD_TS valid; one-cycle pulse.
REQ-013 SHALL have port RD_DATA  output  CHANNELS*DATA_W  entry read out.
REQ-014 SHALL have port RD_TS  output  16  entry timestamp.
REQ-015 SHALL have port RD_LAST  output  1  qualifies RD_VALID on the final entry.
REQ-016 SHALL have port STATE  output  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
REQ-017 SHALL have port WRAPPED  output  1  the buffer has overwritten at least one entry since ARM.

Function
REQ-018 IDLE->ARMED on ARM; ARM clears the write pointer, fill count, and WRAPPED, and latches POST_COUNT.
REQ-019 ARMED/POST: each cycle with SAMPLE_EN high writes CH_DATA into entry wr_ptr; wr_ptr increments modulo DEPTH; the fill count saturates at DEPTH.
REQ-020 WRAPPED sets when a write lands while the fill count is already DEPTH; it stays set until ARM or RESET.
REQ-021 Trigger: in ARMED, SAMPLE_EN high with channel 0 equal to TRIG_PC; the matching sample is stored.
REQ-022 On trigger with latched POST_COUNT=0: ARMED->DONE in the same edge. Otherwise: ARMED->POST, with the post counter loaded with POST_COUNT.
REQ-023 POST: each stored sample decrements the counter; the store that reaches 0 moves the block to DONE.
REQ-024 DONE: no capture; the read pointer starts at the oldest entry, which is wr_ptr if WRAPPED, else 0.
REQ-025 In DONE, RD_REQ produces RD_VALID the next cycle with the next entry oldest-first; there is exactly one entry per RD_REQ.
REQ-026 RD_REQ while RD_VALID is high SHALL be accepted; back-to-back reads sustain one entry per cycle.
REQ-027 RD_LAST accompanies the fill-count-th entry. The cycle after RD_LAST, STATE returns to IDLE.
REQ-028 RD_REQ outside DONE is ignored; no RD_VALID results.
REQ-029 ARM in ARMED, POST, or DONE restarts the capture, per REQ-018; any pending read is dropped.
REQ-030 An ARM and a trigger match in the same cycle: ARM wins and the sample is not stored.
REQ-031 RD_DATA and RD_TS hold their last value when RD_VALID is low.

Reset
REQ-032 RESET asynchronously forces STATE=IDLE, RD_VALID=0, RD_LAST=0, WRAPPED=0, RD_DATA=0, RD_TS=0, and all pointers, counts, and the timestamp counter to 0.
REQ-033 RESET SHALL leave buffer contents undefined; they are never read before being rewritten.
REQ-034 RESET mid-capture or mid-readout discards that capture; the block resumes in IDLE on the first edge after RESET deasserts.

Configuration
REQ-035 Macro TRACE_TIMESTAMP_EN defined: a free-running 16-bit cycle counter (wraps at 65535->0) is stored with each entry and returned on RD_TS.
REQ-036 Macro TRACE_TIMESTAMP_EN undefined: no counter and no timestamp storage; RD_TS is constant 0.

Verification
REQ-037 ARM, POST_COUNT=3, TRIG_PC=0x10, PCs 0x0,0x4,...,0x1C -> DONE after the 0x1C store; 8 reads return 0x0..0x1C in order; RD_LAST on the 8th; WRAPPED=0.
REQ-038 DEPTH=64, trigger after 100 samples, POST_COUNT=10 -> WRAPPED=1; 64 reads; the first read is the 47th stored sample; RD_LAST on read 64.
REQ-039 POST_COUNT=0, trigger on the first sample -> DONE the next edge; one read with RD_LAST=1; then IDLE.
REQ-040 ARM and a matching sample in the same cycle -> STATE=ARMED, fill count 0; a later match triggers normally.
REQ-041 RESET asserted in POST between edges -> STATE=00 immediately; RD_REQ ignored afterwards.
REQ-042 With TRACE_TIMESTAMP_EN, SAMPLE_EN high every other cycle -> consecutive RD_TS values differ by 2; without the macro, RD_TS=0 on every read.

Source files
------------

// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer: armed trigger-on-PC trace capture with post-trigger window and oldest-first readout.
// Optional TRACE_TIMESTAMP_EN stores a free-running 16-bit cycle stamp with each entry.
module pipeline_trace_buffer #(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 64
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         SAMPLE_EN,
  input  logic [CHANNELS*DATA_W-1:0]   CH_DATA,
  input  logic [DATA_W-1:0]            TRIG_PC,
  input  logic                         ARM,
  input  logic [$clog2(DEPTH)-1:0]     POST_COUNT,
  input  logic                         RD_REQ,
  output logic                         RD_VALID,
  output logic [CHANNELS*DATA_W-1:0]   RD_DATA,
  output logic [15:0]                  RD_TS,
  output logic                         RD_LAST,
  output logic [1:0]                   STATE,
  output logic                         WRAPPED
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = CHANNELS * DATA_W;
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] wr_ptr, post_lat, post_cnt, rd_addr;
  logic [AW:0] fill, rd_cnt;
  logic [W-1:0] mem [DEPTH];
  logic [15:0] rd_ts_n;
  logic cap, trig, post_done, rd_go, full;
  assign cap       = SAMPLE_EN && !ARM && (state == ARMED || state == POST);
  assign trig      = cap && state == ARMED && CH_DATA[DATA_W-1:0] == TRIG_PC;
  assign post_done = cap && state == POST && post_cnt == AW'(1);
  assign rd_go     = !ARM && state == DONE && RD_REQ && rd_cnt != fill;
  assign full      = fill == (AW+1)'(DEPTH);
  // Once wrapped, the next slot to be written holds the oldest sample.
  assign rd_addr   = (WRAPPED ? wr_ptr : '0) + rd_cnt[AW-1:0];
  assign STATE     = state;
  always_comb begin
    state_n = ARM ? ARMED
            : trig ? (post_lat == '0 ? DONE : POST)
            : post_done ? DONE
            : (state == DONE && RD_VALID && RD_LAST) ? IDLE
            : state;
  end
  always_ff @(posedge CLK) begin
    if (cap) mem[wr_ptr] <= CH_DATA;
  end
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts;
  logic [15:0] mem_ts [DEPTH];
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) ts <= '0;
    else ts <= ts + 16'd1;
  end
  always_ff @(posedge CLK) begin
    if (cap) mem_ts[wr_ptr] <= ts;
  end
  assign rd_ts_n = mem_ts[rd_addr];
`else
  assign rd_ts_n = '0;
`endif
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      WRAPPED  <= 1'b0;
      post_lat <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      RD_VALID <= 1'b0;
      RD_LAST  <= 1'b0;
      RD_DATA  <= '0;
      RD_TS    <= '0;
    end else begin
      state    <= state_n;
      RD_VALID <= rd_go;
      RD_LAST  <= rd_go && rd_cnt + (AW+1)'(1) == fill;
      if (ARM) begin
        wr_ptr   <= '0;
        fill     <= '0;
        WRAPPED  <= 1'b0;
        post_lat <= POST_COUNT;
        rd_cnt   <= '0;
      end else begin
        if (cap) begin
          wr_ptr <= wr_ptr + 1'b1;
          fill   <= full ? fill : fill + 1'b1;
          if (full) WRAPPED <= 1'b1;
        end
        if (trig) post_cnt <= post_lat;
        else if (cap && state == POST) post_cnt <= post_cnt - 1'b1;
        if (rd_go) begin
          rd_cnt  <= rd_cnt + 1'b1;
          RD_DATA <= mem[rd_addr];
          RD_TS   <= rd_ts_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb_pipeline_trace_buffer: table-driven capture/readout scenarios plus hand-written corner sequences.
module tb_pipeline_trace_buffer;
  logic CLK = 1'b0;
  logic RESET, SAMPLE_EN, ARM, RD_REQ;
  logic [127:0] CH_DATA;
  logic [31:0] TRIG_PC;
  logic [5:0] POST_COUNT;
  logic RD_VALID, RD_LAST, WRAPPED;
  logic [127:0] RD_DATA;
  logic [15:0] RD_TS;
  logic [1:0] STATE;
  int passed = 0;
  int total = 0;

  pipeline_trace_buffer dut (
    .CLK(CLK), .RESET(RESET), .SAMPLE_EN(SAMPLE_EN), .CH_DATA(CH_DATA), .TRIG_PC(TRIG_PC),
    .ARM(ARM), .POST_COUNT(POST_COUNT), .RD_REQ(RD_REQ), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .RD_TS(RD_TS), .RD_LAST(RD_LAST), .STATE(STATE), .WRAPPED(WRAPPED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] trig_pc;
    logic [5:0]  post;
    int          fed;
    int          n;
    logic [31:0] first;
    logic        wrap;
  } scn_t;
  scn_t tbl [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] mk(input logic [31:0] pc);
    return {pc ^ 32'h3000_0000, pc ^ 32'h2000_0000, pc ^ 32'h1000_0000, pc};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input scn_t s, input int idx);
    int i;
    ARM = 1'b1; POST_COUNT = s.post; TRIG_PC = s.trig_pc;
    step();
    ARM = 1'b0;
    chk($sformatf("s%0d armed", idx), 128'(STATE), 128'(2'b01));
    i = 0;
    while (STATE != 2'b11 && i < 300) begin
      SAMPLE_EN = 1'b1; CH_DATA = mk(32'(i * 4));
      step();
      i++;
    end
    SAMPLE_EN = 1'b0;
    chk($sformatf("s%0d done", idx), 128'(STATE), 128'(2'b11));
    chk($sformatf("s%0d fed", idx), 128'(i), 128'(s.fed));
    chk($sformatf("s%0d wrapped", idx), 128'(WRAPPED), 128'(s.wrap));
    RD_REQ = 1'b1;
    for (int k = 0; k < s.n; k++) begin
      step();
      if (k == s.n - 1) RD_REQ = 1'b0;
      chk($sformatf("s%0d rd%0d valid", idx, k), 128'(RD_VALID), 128'(1'b1));
      chk($sformatf("s%0d rd%0d data", idx, k), RD_DATA, mk(s.first + 32'(4 * k)));
      chk($sformatf("s%0d rd%0d last", idx, k), 128'(RD_LAST), 128'(k == s.n - 1));
    end
    step();
    chk($sformatf("s%0d idle", idx), 128'(STATE), 128'(2'b00));
    chk($sformatf("s%0d valid low", idx), 128'(RD_VALID), 128'(1'b0));
    chk($sformatf("s%0d data hold", idx), RD_DATA, mk(s.first + 32'(4 * (s.n - 1))));
  endtask

  initial begin
    logic [15:0] prev;
    int j;
    tbl[0] = '{32'h10,  6'd3,  8,   1,  32'h0,  1'b0};
    tbl[1] = '{32'h18C, 6'd10, 110, 64, 32'hB8, 1'b1};
    tbl[2] = '{32'h0,   6'd0,  1,   1,  32'h0,  1'b0};
    tbl[3] = '{32'hEC,  6'd4,  64,  64, 32'h0,  1'b0};
    tbl[4] = '{32'hF0,  6'd4,  65,  64, 32'h4,  1'b1};
    tbl[0].n = 8;
    RESET = 1'b1; SAMPLE_EN = 1'b0; ARM = 1'b0; RD_REQ = 1'b0;
    CH_DATA = '0; TRIG_PC = '0; POST_COUNT = '0;
    #12;
    chk("rst state", 128'(STATE), 128'(2'b00));
    chk("rst valid", 128'(RD_VALID), 128'(1'b0));
    chk("rst last", 128'(RD_LAST), 128'(1'b0));
    chk("rst wrapped", 128'(WRAPPED), 128'(1'b0));
    chk("rst data", RD_DATA, 128'(0));
    chk("rst ts", 128'(RD_TS), 128'(0));
    RESET = 1'b0;
    step();
    RD_REQ = 1'b1;
    step();
    step();
    RD_REQ = 1'b0;
    chk("idle rdreq valid", 128'(RD_VALID), 128'(1'b0));
    chk("idle rdreq state", 128'(STATE), 128'(2'b00));
    for (int t = 0; t < 5; t++) run(tbl[t], t);
    // ARM coinciding with a matching sample: not stored, a later match triggers
    ARM = 1'b1; POST_COUNT = 6'd0; TRIG_PC = 32'h40; SAMPLE_EN = 1'b1; CH_DATA = mk(32'h40);
    step();
    ARM = 1'b0;
    chk("armtrig state", 128'(STATE), 128'(2'b01));
    step();
    SAMPLE_EN = 1'b0;
    chk("armtrig done", 128'(STATE), 128'(2'b11));
    RD_REQ = 1'b1;
    step();
    RD_REQ = 1'b0;
    chk("armtrig valid", 128'(RD_VALID), 128'(1'b1));
    chk("armtrig data", RD_DATA, mk(32'h40));
    chk("armtrig last", 128'(RD_LAST), 128'(1'b1));
    step();
    chk("armtrig idle", 128'(STATE), 128'(2'b00));
    // reset asserted between edges while in POST
    ARM = 1'b1; POST_COUNT = 6'd5; TRIG_PC = 32'h0;
    step();
    ARM = 1'b0; SAMPLE_EN = 1'b1; CH_DATA = mk(32'h0);
    step();
    SAMPLE_EN = 1'b0;
    chk("post state", 128'(STATE), 128'(2'b10));
    #2 RESET = 1'b1;
    #1 chk("async rst state", 128'(STATE), 128'(2'b00));
    RESET = 1'b0;
    step();
    RD_REQ = 1'b1;
    step();
    step();
    RD_REQ = 1'b0;
    chk("post-rst rdreq valid", 128'(RD_VALID), 128'(1'b0));
    chk("post-rst state", 128'(STATE), 128'(2'b00));
    // samples every other cycle: timestamps two apart, or zero when stamping is off
    ARM = 1'b1; POST_COUNT = 6'd3; TRIG_PC = 32'h8;
    step();
    ARM = 1'b0;
    j = 0;
    while (STATE != 2'b11 && j < 40) begin
      SAMPLE_EN = 1'b1; CH_DATA = mk(32'(j * 4));
      step();
      SAMPLE_EN = 1'b0;
      j++;
      if (STATE != 2'b11) step();
    end
    chk("ts done", 128'(STATE), 128'(2'b11));
    chk("ts fed", 128'(j), 128'(6));
    RD_REQ = 1'b1;
    prev = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 5) RD_REQ = 1'b0;
      chk($sformatf("ts rd%0d data", k), RD_DATA, mk(32'(4 * k)));
`ifdef TRACE_TIMESTAMP_EN
      if (k > 0) chk($sformatf("ts rd%0d delta", k), 128'(16'(RD_TS - prev)), 128'(2));
`else
      chk($sformatf("ts rd%0d zero", k), 128'(RD_TS), 128'(0));
`endif
      prev = RD_TS;
    end
    step();
    chk("ts idle", 128'(STATE), 128'(2'b00));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
